bec_out_monitor: RTL and testbench

- Passive runtime checker on the 39-bit output word of the bec controller FSM.
- Holds a small expectation FSM for the controller's fixed, input-independent output chains.
- Flags any valid word that breaks an armed chain; intended for trojan/fault detection in the LIANA benchmark harness.
- Sits beside the controller and never drives it.

---
 rtl/bec_mon_pkg.sv | 75 +++++++
 rtl/bec_out_monitor_if.sv | 18 +
 rtl/bec_sat_cnt.sv | 42 ++++
 rtl/bec_out_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_bec_out_monitor.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bec_mon_pkg.sv
// -----------------------------------------------------------------------------
// bec_mon_pkg
// Shared definitions for the bec controller output monitor:
//   - mon_state_e     : expectation FSM state (encoding doubles as viol_code)
//   - SIG_*           : 39-bit output-word signatures, bit i-1 carries y_i
//   - VC_*            : violation codes, one per armed (non-IDLE) state
//   - trigger_state() : maps a word seen in IDLE to the state it arms
// -----------------------------------------------------------------------------
package bec_mon_pkg;

  localparam int BEC_Y_W = 39;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A2   = 3'd1,
    ST_A3   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4,
    ST_C2   = 3'd5,
    ST_C3   = 3'd6,
    ST_D2   = 3'd7
  } mon_state_e;

  // y_i lives at bit (i-1)
  localparam logic [BEC_Y_W-1:0] SIG_A1  = (39'd1 << 34) | (39'd1 << 35);
  localparam logic [BEC_Y_W-1:0] SIG_A2  = (39'd1 << 36) | (39'd1 << 37);
  localparam logic [BEC_Y_W-1:0] SIG_A3  = (39'd1 << 2) | (39'd1 << 27) | (39'd1 << 33);
  localparam logic [BEC_Y_W-1:0] SIG_B1  = (39'd1 << 0);
  localparam logic [BEC_Y_W-1:0] SIG_B2  = (39'd1 << 1) | (39'd1 << 2);
  localparam logic [BEC_Y_W-1:0] SIG_B3  = (39'd1 << 38);
  localparam logic [BEC_Y_W-1:0] SIG_C1  = (39'd1 << 11);
  localparam logic [BEC_Y_W-1:0] SIG_C2  = (39'd1 << 12);
  localparam logic [BEC_Y_W-1:0] SIG_C3a = (39'd1 << 2);
  localparam logic [BEC_Y_W-1:0] SIG_C3b = (39'd1 << 33);
  localparam logic [BEC_Y_W-1:0] SIG_D1  = (39'd1 << 5) | (39'd1 << 14);
  localparam logic [BEC_Y_W-1:0] SIG_D2  = (39'd1 << 13);

  localparam logic [2:0] VC_NONE = 3'd0;
  localparam logic [2:0] VC_A2   = 3'd1;
  localparam logic [2:0] VC_A3   = 3'd2;
  localparam logic [2:0] VC_B2   = 3'd3;
  localparam logic [2:0] VC_B3   = 3'd4;
  localparam logic [2:0] VC_C2   = 3'd5;
  localparam logic [2:0] VC_C3   = 3'd6;
  localparam logic [2:0] VC_D2   = 3'd7;

  // State armed by a word observed in IDLE; non-trigger words keep IDLE.
  function automatic mon_state_e trigger_state(input logic [BEC_Y_W-1:0] w);
    mon_state_e s;
    s = ST_IDLE;
    if (w == SIG_A1)      s = ST_A2;
    else if (w == SIG_B1) s = ST_B2;
    else if (w == SIG_C1) s = ST_C2;
    else if (w == SIG_D1) s = ST_D2;
    return s;
  endfunction

  // Violation code reported when the given armed state sees a bad word.
  function automatic logic [2:0] viol_code_of(input mon_state_e s);
    logic [2:0] c;
    c = VC_NONE;
    case (s)
      ST_A2:   c = VC_A2;
      ST_A3:   c = VC_A3;
      ST_B2:   c = VC_B2;
      ST_B3:   c = VC_B3;
      ST_C2:   c = VC_C2;
      ST_C3:   c = VC_C3;
      ST_D2:   c = VC_D2;
      default: c = VC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bec_out_monitor_if.sv
// -----------------------------------------------------------------------------
// bec_out_monitor_if
// Carries the controller output word into the monitor.
//   y_vec   [Y_W] : controller output word, bit i-1 = y_i
//   y_valid [1]   : y_vec is a real controller step
// Modports: master (controller side, drives), slave (monitor side, samples).
// -----------------------------------------------------------------------------
interface bec_out_monitor_if
  import bec_mon_pkg::*;
#(
  parameter int Y_W = BEC_Y_W
);
  logic [Y_W-1:0] y_vec;
  logic           y_valid;

  modport master (output y_vec, output y_valid);
  modport slave  (input  y_vec, input  y_valid);
endinterface

// File: rtl/bec_sat_cnt.sv
// -----------------------------------------------------------------------------
// bec_sat_cnt
// Saturating up-counter with synchronous clear.
//   clk [1]     : clock, rising edge
//   rst [1]     : asynchronous active-high reset
//   inc [1]     : count one event
//   clr [1]     : synchronous clear; an inc in the same cycle counts after it
//   q   [CNT_W] : count, sticks at 2^CNT_W-1
// -----------------------------------------------------------------------------
module bec_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      // clear first, then record this cycle's event
      cnt_d = CNT_W'(inc);
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/bec_out_monitor.sv
// -----------------------------------------------------------------------------
// bec_out_monitor
// Passive checker on the bec controller output word. An expectation FSM is
// armed by trigger words in IDLE and then demands the controller's fixed
// follow-on words; any other valid word in an armed state is a violation.
// Optional capture of the offending and preceding words: BEC_MON_CAPTURE_EN.
//   clk        [1]     : sampling clock, rising edge
//   rst        [1]     : asynchronous active-high reset
//   mon_if     slave   : y_vec / y_valid from the controller
//   clr        [1]     : sync clear of alarm, viol_cnt, done_cnt, viol_code
//   alarm      [1]     : sticky violation flag
//   viol_pulse [1]     : one-cycle pulse per violation
//   viol_code  [3]     : armed state in which the last violation occurred
//   viol_cnt   [CNT_W] : saturating violation count
//   done_cnt   [CNT_W] : saturating completed-chain count
//   mon_state  [3]     : current expectation state
//   viol_word  [Y_W]   : (capture build) offending word of last violation
//   viol_prev  [Y_W]   : (capture build) valid word preceding it
// -----------------------------------------------------------------------------
module bec_out_monitor
  import bec_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int Y_W   = BEC_Y_W
) (
  input  logic             clk,
  input  logic             rst,
  bec_out_monitor_if.slave mon_if,
  input  logic             clr,
  output logic             alarm,
  output logic             viol_pulse,
  output logic [2:0]       viol_code,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [2:0]       mon_state
`ifdef BEC_MON_CAPTURE_EN
  ,
  output logic [Y_W-1:0]   viol_word,
  output logic [Y_W-1:0]   viol_prev
`endif
);

  logic [Y_W-1:0] y_w;
  logic           y_valid_w;

  assign y_w       = mon_if.y_vec;
  assign y_valid_w = mon_if.y_valid;

  mon_state_e state_q, state_d;
  mon_state_e trig_w;
  logic       viol_w;
  logic       done_w;

  logic       alarm_q, alarm_d;
  logic       viol_pulse_q;
  logic [2:0] viol_code_q, viol_code_d;

  // ---------------------------------------------------------------------------
  // Expectation FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    viol_w  = 1'b0;
    done_w  = 1'b0;
    trig_w  = trigger_state(y_w);
    if (y_valid_w) begin
      case (state_q)
        ST_IDLE: state_d = trig_w;
        ST_A2: begin
          if (y_w == SIG_A2) state_d = ST_A3;
          else               viol_w  = 1'b1;
        end
        ST_A3: begin
          if (y_w == SIG_A3) begin
            state_d = ST_IDLE;
            done_w  = 1'b1;
          end else begin
            viol_w = 1'b1;
          end
        end
        ST_B2: begin
          if (y_w == SIG_B2) state_d = ST_B3;
          else               viol_w  = 1'b1;
        end
        ST_B3: begin
          if (y_w == SIG_B3) begin
            state_d = ST_IDLE;
            done_w  = 1'b1;
          end else begin
            viol_w = 1'b1;
          end
        end
        ST_C2: begin
          if (y_w == SIG_C2) state_d = ST_C3;
          else               viol_w  = 1'b1;
        end
        ST_C3: begin
          if ((y_w == SIG_C3a) || (y_w == SIG_C3b) || (y_w == '0)) begin
            state_d = ST_IDLE;
            done_w  = 1'b1;
          end else begin
            viol_w = 1'b1;
          end
        end
        ST_D2: begin
          if (y_w == SIG_D2) begin
            state_d = ST_IDLE;
            done_w  = 1'b1;
          end else begin
            viol_w = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // The offending word is re-examined as an IDLE trigger so a fresh chain
      // starting on it is not lost.
      if (viol_w) state_d = trig_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered reporting
  // ---------------------------------------------------------------------------
  always_comb begin
    alarm_d     = alarm_q;
    viol_code_d = viol_code_q;
    if (clr) begin
      alarm_d     = 1'b0;
      viol_code_d = VC_NONE;
    end
    // a violation in the same cycle as clr is recorded after the clear
    if (viol_w) begin
      alarm_d     = 1'b1;
      viol_code_d = viol_code_of(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q      <= 1'b0;
      viol_pulse_q <= 1'b0;
      viol_code_q  <= VC_NONE;
    end else begin
      alarm_q      <= alarm_d;
      viol_pulse_q <= viol_w;
      viol_code_q  <= viol_code_d;
    end
  end

  bec_sat_cnt #(.CNT_W(CNT_W)) u_viol_cnt (
    .clk (clk),
    .rst (rst),
    .inc (viol_w),
    .clr (clr),
    .q   (viol_cnt)
  );

  bec_sat_cnt #(.CNT_W(CNT_W)) u_done_cnt (
    .clk (clk),
    .rst (rst),
    .inc (done_w),
    .clr (clr),
    .q   (done_cnt)
  );

`ifdef BEC_MON_CAPTURE_EN
  logic [Y_W-1:0] last_q, last_d;
  logic [Y_W-1:0] viol_word_q, viol_word_d;
  logic [Y_W-1:0] viol_prev_q, viol_prev_d;

  always_comb begin
    last_d      = last_q;
    viol_word_d = viol_word_q;
    viol_prev_d = viol_prev_q;
    // last_q tracks the history of valid words and is not affected by clr
    if (y_valid_w) last_d = y_w;
    if (clr) begin
      viol_word_d = '0;
      viol_prev_d = '0;
    end
    if (viol_w) begin
      viol_word_d = y_w;
      viol_prev_d = last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= '0;
      viol_word_q <= '0;
      viol_prev_q <= '0;
    end else begin
      last_q      <= last_d;
      viol_word_q <= viol_word_d;
      viol_prev_q <= viol_prev_d;
    end
  end

  assign viol_word = viol_word_q;
  assign viol_prev = viol_prev_q;
`endif

  assign alarm      = alarm_q;
  assign viol_pulse = viol_pulse_q;
  assign viol_code  = viol_code_q;
  assign mon_state  = state_q;

endmodule

// File: tb/tb_bec_out_monitor.sv
// -----------------------------------------------------------------------------
// tb_bec_out_monitor
// Table-driven check of bec_out_monitor with a scoreboard queue of expected
// outputs, plus hand-written sequences for saturation, clr collisions and
// asynchronous reset in mid-chain.
// -----------------------------------------------------------------------------
module tb_bec_out_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic       alarm;
  logic       viol_pulse;
  logic [2:0] viol_code;
  logic [7:0] viol_cnt;
  logic [7:0] done_cnt;
  logic [2:0] mon_state;
`ifdef BEC_MON_CAPTURE_EN
  logic [38:0] viol_word;
  logic [38:0] viol_prev;
`endif

  bec_out_monitor_if #(.Y_W(39)) mif ();

  bec_out_monitor #(.CNT_W(8), .Y_W(39)) dut (
    .clk        (clk),
    .rst        (rst),
    .mon_if     (mif),
    .clr        (clr),
    .alarm      (alarm),
    .viol_pulse (viol_pulse),
    .viol_code  (viol_code),
    .viol_cnt   (viol_cnt),
    .done_cnt   (done_cnt),
    .mon_state  (mon_state)
`ifdef BEC_MON_CAPTURE_EN
    ,
    .viol_word  (viol_word),
    .viol_prev  (viol_prev)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [38:0] y;
    logic        c;
    logic        alarm;
    logic        pulse;
    logic [2:0]  code;
    logic [7:0]  vcnt;
    logic [7:0]  dcnt;
    logic [2:0]  st;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;
  vec_t sb[$];
  vec_t tbl[24];

  // word with y_a, y_b, y_c set (index 0 = unused)
  function automatic logic [38:0] yw(input int a = 0, input int b = 0, input int c = 0);
    logic [38:0] w;
    w = '0;
    if (a > 0) w[a-1] = 1'b1;
    if (b > 0) w[b-1] = 1'b1;
    if (c > 0) w[c-1] = 1'b1;
    return w;
  endfunction

  function automatic vec_t mk(input bit v, input logic [38:0] y, input bit c,
                              input bit al, input bit pu, input int code,
                              input int vc, input int dc, input int st);
    vec_t t;
    t.v = v; t.y = y; t.c = c;
    t.alarm = al; t.pulse = pu; t.code = 3'(code);
    t.vcnt = 8'(vc); t.dcnt = 8'(dc); t.st = 3'(st);
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    cmp({tag, ".alarm"},     64'(alarm),      64'(e.alarm));
    cmp({tag, ".viol_pulse"},64'(viol_pulse), 64'(e.pulse));
    cmp({tag, ".viol_code"}, 64'(viol_code),  64'(e.code));
    cmp({tag, ".viol_cnt"},  64'(viol_cnt),   64'(e.vcnt));
    cmp({tag, ".done_cnt"},  64'(done_cnt),   64'(e.dcnt));
    cmp({tag, ".mon_state"}, 64'(mon_state),  64'(e.st));
    $display("[TB] %s v=%0d y=%010h clr=%0d -> alarm=%0d pulse=%0d code=%0d vcnt=%0d dcnt=%0d st=%0d",
             tag, e.v, e.y, e.c, alarm, viol_pulse, viol_code, viol_cnt, done_cnt, mon_state);
  endtask

  // Drive one word at the falling edge; expectations go into the scoreboard
  // and are compared 1 ns after the sampling edge.
  task automatic apply(input vec_t t, input string tag, input bit chk);
    vec_t e;
    @(negedge clk);
    mif.y_valid = t.v;
    mif.y_vec   = t.y;
    clr         = t.c;
    if (chk) sb.push_back(t);
    @(posedge clk);
    #1;
    if (chk) begin
      e = sb.pop_front();
      check_outs(tag, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    mif.y_valid = 1'b0;
    mif.y_vec   = '0;

    tbl[0]  = mk(1, yw(35,36),    0, 0,0,0,0,0,1);
    tbl[1]  = mk(1, yw(37,38),    0, 0,0,0,0,0,2);
    tbl[2]  = mk(0, yw(1),        0, 0,0,0,0,0,2);
    tbl[3]  = mk(1, yw(3,28,34),  0, 0,0,0,0,1,0);
    tbl[4]  = mk(1, yw(1),        0, 0,0,0,0,1,3);
    tbl[5]  = mk(1, yw(2,3),      0, 0,0,0,0,1,4);
    tbl[6]  = mk(1, yw(),         0, 1,1,4,1,1,0);
    tbl[7]  = mk(0, yw(),         0, 1,0,4,1,1,0);
    tbl[8]  = mk(0, yw(),         1, 0,0,0,0,0,0);
    tbl[9]  = mk(1, yw(12),       0, 0,0,0,0,0,5);
    tbl[10] = mk(1, yw(13),       0, 0,0,0,0,0,6);
    tbl[11] = mk(1, yw(),         0, 0,0,0,0,1,0);
    tbl[12] = mk(1, yw(12),       0, 0,0,0,0,1,5);
    tbl[13] = mk(1, yw(35,36),    0, 1,1,5,1,1,1);
    tbl[14] = mk(1, yw(37,38),    0, 1,0,5,1,1,2);
    tbl[15] = mk(1, yw(3,28,34),  0, 1,0,5,1,2,0);
    tbl[16] = mk(1, yw(12),       0, 1,0,5,1,2,5);
    tbl[17] = mk(1, yw(13),       0, 1,0,5,1,2,6);
    tbl[18] = mk(1, yw(34),       0, 1,0,5,1,3,0);
    tbl[19] = mk(1, yw(6,15),     0, 1,0,5,1,3,7);
    tbl[20] = mk(1, yw(14),       0, 1,0,5,1,4,0);
    tbl[21] = mk(1, yw(39),       0, 1,0,5,1,4,0);
    tbl[22] = mk(1, yw(6,15),     0, 1,0,5,1,4,7);
    tbl[23] = mk(1, yw(13),       0, 1,1,7,2,4,0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    z = mk(0, yw(), 0, 0,0,0,0,0,0);
    check_outs("reset", z);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i], $sformatf("row%0d", i), 1'b1);
    end
`ifdef BEC_MON_CAPTURE_EN
    cmp("cap.viol_word", 64'(viol_word), 64'(yw(13)));
    cmp("cap.viol_prev", 64'(viol_prev), 64'(yw(6,15)));
`endif

    // saturation: first {y1} arms B2, each following {y1} violates and rearms
    apply(mk(0, yw(), 1, 0,0,0,0,0,0), "sat_clr", 1'b1);
    for (int i = 0; i < 300; i++) begin
      apply(mk(1, yw(1), 0, 0,0,0,0,0,0), "sat", 1'b0);
    end
    apply(mk(1, yw(1), 0, 1,1,3,255,0,3), "sat_end", 1'b1);
    apply(mk(1, yw(1), 1, 1,1,3,1,0,3),   "clr_viol", 1'b1);
    apply(mk(1, yw(2,3), 0, 1,0,3,1,0,4), "b3", 1'b1);
    apply(mk(1, yw(39), 1, 0,0,0,0,1,0),  "clr_done", 1'b1);

    // reset in mid-chain with valid gaps
    apply(mk(1, yw(12), 0, 0,0,0,0,1,5),     "rs_c2", 1'b1);
    apply(mk(1, yw(), 0, 1,1,5,1,1,0),       "rs_viol", 1'b1);
    apply(mk(1, yw(35,36), 0, 1,0,5,1,1,1),  "rs_a2", 1'b1);
    apply(mk(0, yw(35,36), 0, 1,0,5,1,1,1),  "rs_gap1", 1'b1);
    apply(mk(1, yw(37,38), 0, 1,0,5,1,1,2),  "rs_a3", 1'b1);
    apply(mk(0, yw(), 0, 1,0,5,1,1,2),       "rs_gap2", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_outs("async_rst", mk(0, yw(), 0, 0,0,0,0,0,0));
`ifdef BEC_MON_CAPTURE_EN
    cmp("rst.viol_word", 64'(viol_word), 64'd0);
    cmp("rst.viol_prev", 64'(viol_prev), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1, yw(3,28,34), 0, 0,0,0,0,0,0), "post_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
